// File: rtl/boot_loader_ctrl_pkg.sv
// Shared definitions for the boot loader: FSM state codes, CPU register map
// and CTRL bit positions.
package boot_loader_ctrl_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_COPY_RD   = 3'd0,
    ST_COPY_WR   = 3'd1,
    ST_RUN_BOOT  = 3'd2,
    ST_RST_PULSE = 3'd3,
    ST_RUN       = 3'd4
  } state_e;

  localparam logic REG_CTRL   = 1'b0;
  localparam logic REG_STATUS = 1'b1;

  localparam int CTRL_BOOT_EXIT_BIT = 0;
  localparam int CTRL_REBOOT_BIT    = 1;

  localparam int STATUS_STATE_LSB = 0;
  localparam int STATUS_CNT_LSB   = 4;

  // Boot image sits at the top of SRAM; wraps modulo the SRAM size.
  function automatic logic [63:0] boot_base(input int sram_w, input int rom_w);
    logic [63:0] mask;
    mask = (64'd1 << sram_w) - 64'd1;
    return ((64'd1 << sram_w) - (64'd1 << rom_w)) & mask;
  endfunction

endpackage

// File: rtl/boot_loader_ctrl_regs.sv
// CPU register slave for the boot loader: decodes CTRL writes into
// boot-exit / reboot requests and returns CTRL/STATUS with a registered ack.
module boot_loader_regs
  import boot_loader_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_cpu_valid,
  input  logic                i_cpu_addr,
  input  logic [DATA_W-1:0]   i_cpu_wdata,
  input  logic [DATA_W/8-1:0] i_cpu_wstrb,
  input  state_e              i_state,
  input  logic [CNT_W-1:0]    i_cnt,
  output logic [DATA_W-1:0]   o_cpu_rdata,
  output logic                o_cpu_ready,
  output logic                o_boot_exit,
  output logic                o_reboot
);

  logic              w_ctrl_wr;
  logic [DATA_W-1:0] w_status;
  logic              w_unused_wdata;
  logic              r_ready;
  logic [DATA_W-1:0] r_rdata;

  assign w_ctrl_wr      = i_cpu_valid && (|i_cpu_wstrb) && (i_cpu_addr == REG_CTRL);
  assign o_reboot       = w_ctrl_wr && i_cpu_wdata[CTRL_REBOOT_BIT];
  // Reboot takes priority when both bits are written together.
  assign o_boot_exit    = w_ctrl_wr && i_cpu_wdata[CTRL_BOOT_EXIT_BIT]
                          && !i_cpu_wdata[CTRL_REBOOT_BIT];
  assign w_unused_wdata = ^i_cpu_wdata;

  always_comb begin
    w_status = '0;
    w_status[STATUS_STATE_LSB +: STATE_W] = i_state;
    w_status[STATUS_CNT_LSB +: CNT_W]     = i_cnt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ready <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ready <= i_cpu_valid;
      if (i_cpu_valid) begin
        r_rdata <= (i_cpu_addr == REG_STATUS) ? w_status : '0;
      end
    end
  end

  assign o_cpu_ready = r_ready;
  assign o_cpu_rdata = r_rdata;

endmodule

// File: rtl/boot_loader_ctrl.sv
// Boot loader controller: copies the boot ROM image into the top of SRAM
// while holding the CPU in reset, then sequences boot exit and reboot.
module boot_loader_ctrl
  import boot_loader_ctrl_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int SRAM_ADDR_W    = 15,
  parameter int BOOTROM_ADDR_W = 12,
  parameter int RST_CYCLES     = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cpu_valid,
  input  logic                      cpu_addr,
  input  logic [DATA_W-1:0]         cpu_wdata,
  input  logic [DATA_W/8-1:0]       cpu_wstrb,
  output logic [DATA_W-1:0]         cpu_rdata,
  output logic                      cpu_ready,
  output logic                      rom_valid,
  output logic [BOOTROM_ADDR_W-3:0] rom_addr,
  input  logic [DATA_W-1:0]         rom_rdata,
  input  logic                      rom_ready,
  output logic                      sram_valid,
  output logic [SRAM_ADDR_W-1:0]    sram_addr,
  output logic [DATA_W-1:0]         sram_wdata,
  output logic [DATA_W/8-1:0]       sram_wstrb,
  input  logic                      sram_ready,
  output logic                      boot,
  output logic                      cpu_rst
);

  localparam int                CNT_W     = BOOTROM_ADDR_W - 2;
  localparam logic [CNT_W-1:0]  LAST_WORD = '1;
  localparam int                PCNT_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(RST_CYCLES - 1);
  localparam logic [63:0]       BOOT_BASE = boot_base(SRAM_ADDR_W, BOOTROM_ADDR_W);

  state_e            r_state;
  state_e            w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_word;
  logic [PCNT_W-1:0] r_pcnt;
  logic              w_boot_exit;
  logic              w_reboot;
  logic              w_reboot_ok;
  logic              w_rom_hs;
  logic              w_sram_hs;
  logic              w_last;

  assign w_rom_hs    = (r_state == ST_COPY_RD) && rom_ready;
  assign w_sram_hs   = (r_state == ST_COPY_WR) && sram_ready;
  assign w_last      = (r_cnt == LAST_WORD);
  assign w_reboot_ok = w_reboot && ((r_state == ST_RUN_BOOT) || (r_state == ST_RUN));

  boot_loader_regs #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_regs (
    .clk         (clk),
    .rst         (rst),
    .i_cpu_valid (cpu_valid),
    .i_cpu_addr  (cpu_addr),
    .i_cpu_wdata (cpu_wdata),
    .i_cpu_wstrb (cpu_wstrb),
    .i_state     (r_state),
    .i_cnt       (r_cnt),
    .o_cpu_rdata (cpu_rdata),
    .o_cpu_ready (cpu_ready),
    .o_boot_exit (w_boot_exit),
    .o_reboot    (w_reboot)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_COPY_RD;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_COPY_RD:   if (rom_ready) w_next = ST_COPY_WR;
      ST_COPY_WR:   if (sram_ready) w_next = w_last ? ST_RUN_BOOT : ST_COPY_RD;
      ST_RUN_BOOT: begin
        if (w_reboot) begin
          w_next = ST_COPY_RD;
        end else if (w_boot_exit) begin
          w_next = ST_RST_PULSE;
        end
      end
      ST_RST_PULSE: if (r_pcnt == PCNT_LAST) w_next = ST_RUN;
      ST_RUN:       if (w_reboot) w_next = ST_COPY_RD;
      default:      w_next = ST_COPY_RD;
    endcase
  end

  always_comb begin
    rom_valid  = 1'b0;
    sram_valid = 1'b0;
    sram_wstrb = '0;
    boot       = 1'b0;
    cpu_rst    = 1'b0;
    case (r_state)
      ST_COPY_RD: begin
        rom_valid = 1'b1;
        boot      = 1'b1;
        cpu_rst   = 1'b1;
      end
      ST_COPY_WR: begin
        sram_valid = 1'b1;
        sram_wstrb = '1;
        boot       = 1'b1;
        cpu_rst    = 1'b1;
      end
      ST_RUN_BOOT:  boot    = 1'b1;
      ST_RST_PULSE: cpu_rst = 1'b1;
      default: ;
    endcase
  end

  // Copy datapath: word counter, captured ROM word, reset-pulse timer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_word <= '0;
      r_pcnt <= '0;
    end else begin
      if (w_rom_hs) begin
        r_word <= rom_rdata;
      end
      if (w_sram_hs && !w_last) begin
        r_cnt <= r_cnt + 1'b1;
      end else if (w_reboot_ok) begin
        r_cnt <= '0;
      end
      if (r_state == ST_RST_PULSE) begin
        r_pcnt <= r_pcnt + 1'b1;
      end else begin
        r_pcnt <= '0;
      end
    end
  end

  assign rom_addr   = r_cnt;
  assign sram_wdata = r_word;
  assign sram_addr  = SRAM_ADDR_W'(BOOT_BASE + (64'(r_cnt) << 2));

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Scoreboard bench for boot_loader_ctrl: ROM/SRAM responders with optional
// stalls, expected SRAM writes and CPU read data queued and popped by monitors.
module tb_boot_loader_ctrl;

  localparam int NWORDS = 1024;
  localparam int BOUND  = 30000;

  typedef struct packed {
    logic [14:0] a;
    logic [31:0] d;
  } sw_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_valid;
  logic        cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_wstrb;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        rom_valid;
  logic [9:0]  rom_addr;
  logic [31:0] rom_rdata;
  logic        rom_ready;
  logic        sram_valid;
  logic [14:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [3:0]  sram_wstrb;
  logic        sram_ready;
  logic        boot;
  logic        cpu_rst;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] cpu_q[$];
  sw_t         sram_q[$];
  sw_t         mon_e;
  bit          rom_stall  = 0;
  bit          sram_stall = 0;
  bit          spurious   = 0;
  logic        prev_valid = 1'b0;

  always #5 clk = ~clk;

  boot_loader_ctrl #(
    .DATA_W         (32),
    .SRAM_ADDR_W    (15),
    .BOOTROM_ADDR_W (12),
    .RST_CYCLES     (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_valid  (cpu_valid),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_wstrb  (cpu_wstrb),
    .cpu_rdata  (cpu_rdata),
    .cpu_ready  (cpu_ready),
    .rom_valid  (rom_valid),
    .rom_addr   (rom_addr),
    .rom_rdata  (rom_rdata),
    .rom_ready  (rom_ready),
    .sram_valid (sram_valid),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_wstrb (sram_wstrb),
    .sram_ready (sram_ready),
    .boot       (boot),
    .cpu_rst    (cpu_rst)
  );

  function automatic logic [31:0] rom_word(input int i);
    return 32'(i) * 32'h9E3779B9 + 32'h1234_5678;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Image lands at 0x7000 + 4*i for the default 32 KiB SRAM / 4 KiB ROM.
  task automatic push_copy();
    sram_q.delete();
    for (int i = 0; i < NWORDS; i++) begin
      sram_q.push_back('{a: 15'(32'h7000 + 4 * i), d: rom_word(i)});
    end
  endtask

  task automatic cpu_access(input logic a, input logic [31:0] wd, input logic [3:0] ws,
                            input logic [31:0] exp);
    cpu_q.push_back(exp);
    cpu_valid = 1'b1;
    cpu_addr  = a;
    cpu_wdata = wd;
    cpu_wstrb = ws;
    @(posedge clk); #1;
    cpu_valid = 1'b0;
    cpu_wstrb = 4'h0;
  endtask

  task automatic wait_rom(input int idx, input string name);
    int n = 0;
    while (!(rom_valid && rom_addr == 10'(idx)) && n < BOUND) begin
      @(posedge clk); #1; n++;
    end
    chk(name, 32'(n < BOUND), 1);
  endtask

  task automatic wait_sram(input logic [14:0] a, input string name);
    int n = 0;
    while (!(sram_valid && sram_addr == a) && n < BOUND) begin
      @(posedge clk); #1; n++;
    end
    chk(name, 32'(n < BOUND), 1);
  endtask

  task automatic wait_run_boot(input string name);
    int n = 0;
    while (cpu_rst && n < BOUND) begin
      @(posedge clk); #1; n++;
    end
    chk(name, 32'(n < BOUND), 1);
    chk({name, "_boot"}, 32'(boot), 1);
    chk({name, "_all_written"}, 32'(sram_q.size()), 0);
  endtask

  // ROM responder: latency 1 by default, 0-5 cycles when stalling.
  initial begin : rom_resp
    int         wait_n;
    logic [9:0] first_addr;
    wait_n = -1;
    first_addr = '0;
    rom_ready = 1'b0;
    rom_rdata = '0;
    forever begin
      @(posedge clk); #1;
      rom_ready = 1'b0;
      if (rst || !rom_valid) begin
        wait_n = -1;
        if (!rst && spurious) rom_ready = 1'($urandom_range(0, 1));
      end else begin
        if (wait_n < 0) begin
          wait_n = rom_stall ? int'($urandom_range(0, 5)) : 1;
          first_addr = rom_addr;
        end
        if (wait_n == 0) begin
          chk("rom_addr_stable", 32'(rom_addr), 32'(first_addr));
          rom_rdata = rom_word(int'(rom_addr));
          rom_ready = 1'b1;
          wait_n = -1;
        end else begin
          wait_n--;
        end
      end
    end
  end

  // SRAM responder: immediate ready by default, 0-5 cycles when stalling.
  initial begin : sram_resp
    int          wait_n;
    logic [14:0] first_addr;
    logic [31:0] first_data;
    wait_n = -1;
    first_addr = '0;
    first_data = '0;
    sram_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      sram_ready = 1'b0;
      if (rst || !sram_valid) begin
        wait_n = -1;
        if (!rst && spurious) sram_ready = 1'($urandom_range(0, 1));
      end else begin
        if (wait_n < 0) begin
          wait_n = sram_stall ? int'($urandom_range(0, 5)) : 0;
          first_addr = sram_addr;
          first_data = sram_wdata;
        end
        if (wait_n == 0) begin
          chk("sram_addr_stable", 32'(sram_addr), 32'(first_addr));
          chk("sram_wdata_stable", sram_wdata, first_data);
          sram_ready = 1'b1;
          wait_n = -1;
        end else begin
          wait_n--;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && rom_valid && rom_ready) begin
      chk("rom_no_sram_overlap", 32'(sram_valid), 0);
    end
    if (!rst && sram_valid && sram_ready) begin
      chk("sram_no_rom_overlap", 32'(rom_valid), 0);
      chk("sram_wstrb", 32'(sram_wstrb), 32'hF);
      if (sram_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sram_extra_write: addr 0x%04h written, no write expected", sram_addr);
      end else begin
        mon_e = sram_q.pop_front();
        chk("sram_addr", 32'(sram_addr), 32'(mon_e.a));
        chk("sram_wdata", sram_wdata, mon_e.d);
      end
    end
  end

  always @(negedge clk) begin
    if (cpu_ready || prev_valid) begin
      chk("cpu_ready_timing", 32'(cpu_ready), 32'(prev_valid));
    end
    if (cpu_ready) begin
      if (cpu_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL cpu_extra_ready: rdata 0x%08h, no access pending", cpu_rdata);
      end else begin
        chk("cpu_rdata", cpu_rdata, cpu_q.pop_front());
      end
    end
    prev_valid = cpu_valid;
  end

  initial begin
    cpu_valid = 1'b0;
    cpu_addr  = 1'b0;
    cpu_wdata = '0;
    cpu_wstrb = '0;
    rst       = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_boot", 32'(boot), 1);
    chk("rst_cpu_rst", 32'(cpu_rst), 1);
    chk("rst_sram_valid", 32'(sram_valid), 0);
    chk("rst_cpu_ready", 32'(cpu_ready), 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);

    // First boot copy, fixed latencies.
    push_copy();
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rel_rom_valid", 32'(rom_valid), 1);
    chk("rel_rom_addr", 32'(rom_addr), 0);
    wait_run_boot("copy1_done");
    cpu_access(1'b1, 32'h0, 4'h0, 32'h0000_3FF2);
    @(posedge clk); #1;

    // Boot exit: four reset-pulse cycles, then RUN.
    cpu_access(1'b0, 32'h1, 4'hF, 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk("pulse_cpu_rst", 32'(cpu_rst), 1);
      chk("pulse_boot", 32'(boot), 0);
      @(posedge clk); #1;
    end
    chk("run_cpu_rst", 32'(cpu_rst), 0);
    chk("run_boot", 32'(boot), 0);
    cpu_access(1'b1, 32'h0, 4'h0, 32'h0000_3FF4);
    @(posedge clk); #1;

    // Writes that must leave RUN untouched.
    cpu_access(1'b0, 32'h1, 4'hF, 32'h0);
    cpu_access(1'b1, 32'h2, 4'hF, 32'h0000_3FF4);
    cpu_access(1'b0, 32'h2, 4'h0, 32'h0);
    @(posedge clk); #1;
    chk("run_still_boot", 32'(boot), 0);
    cpu_access(1'b1, 32'h0, 4'h0, 32'h0000_3FF4);
    @(posedge clk); #1;

    // Reboot from RUN with stalls and stray ready pulses.
    rom_stall  = 1;
    sram_stall = 1;
    spurious   = 1;
    push_copy();
    cpu_access(1'b0, 32'h2, 4'hF, 32'h0);
    chk("reboot_boot", 32'(boot), 1);
    chk("reboot_cpu_rst", 32'(cpu_rst), 1);
    chk("reboot_rom_valid", 32'(rom_valid), 1);
    chk("reboot_rom_addr", 32'(rom_addr), 0);
    @(posedge clk); #1;
    cpu_access(1'b0, 32'h3, 4'hF, 32'h0);
    wait_rom(32'h123, "reach_rom_0x123");
    cpu_access(1'b1, 32'h0, 4'h0, 32'h0000_1230);
    wait_sram(15'h748C, "reach_sram_0x123");
    cpu_access(1'b1, 32'h0, 4'h0, 32'h0000_1231);
    wait_run_boot("copy2_done");

    // CTRL=0x3 in RUN_BOOT is a reboot.
    rom_stall  = 0;
    sram_stall = 0;
    spurious   = 0;
    @(posedge clk); #1;
    push_copy();
    cpu_access(1'b0, 32'h3, 4'hF, 32'h0);
    chk("reboot3_boot", 32'(boot), 1);
    chk("reboot3_cpu_rst", 32'(cpu_rst), 1);
    chk("reboot3_rom_addr", 32'(rom_addr), 0);
    cpu_access(1'b1, 32'h0, 4'h0, 32'h0000_0000);

    // Reset in the middle of word 500's SRAM write.
    wait_rom(500, "reach_rom_500");
    cpu_access(1'b1, 32'h0, 4'h0, 32'h0000_1F40);
    wait_sram(15'h77D0, "reach_sram_500");
    rst = 1'b1;
    sram_q.delete();
    #1;
    chk("abort_sram_valid", 32'(sram_valid), 0);
    chk("abort_boot", 32'(boot), 1);
    chk("abort_cpu_rst", 32'(cpu_rst), 1);
    chk("abort_cpu_rdata", cpu_rdata, 0);
    repeat (2) @(posedge clk);
    #1;
    push_copy();
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rerun_rom_valid", 32'(rom_valid), 1);
    chk("rerun_rom_addr", 32'(rom_addr), 0);
    wait_run_boot("copy4_done");

    repeat (3) @(posedge clk);
    #1;
    chk("cpu_acks_outstanding", 32'(cpu_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
